nvram_sequencer: RTL
====================

// Module: nvram_sequencer
// PURPOSE
//  Control sequencer directly upstream of the X2212-style NVRAM wrapper; drives its STORE/RECALLn/SIREn pins.
//  Issues the power-up recall and the store/recall cycles requested by the CPU latch or by a power-fail (DCOKn) edge.
//  Times the 512-cycle shadow copy of each store and blocks new requests until it completes.
//  Provides a 256-byte upload scan so the HPS can save NVRAM contents to SD.
//  Drives the NVRAM address mux during the scan.
// PARAMETERS
//  STORE_CYC   4    cycles STORE held high
//  COPY_CYC    512  cycles waited after STORE drops (shadow copy)
//  RECALL_CYC  2    cycles RECALLn/SIREn held low
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  synchronous reset, active low
//  store_req  in   1  1-cycle pulse from CPU NVRAM-control latch
//  recall_req in   1  1-cycle pulse from CPU NVRAM-control latch
//  dcok_n     in   1  high = supply failing; a 0->1 edge requests a store
//  upl_req    in   1  1-cycle pulse from HPS: dump all 256 bytes
//  upl_ready  in   1  HPS accepts the current beat
//  nv_dout    in   8  NVRAM read data, 1-cycle registered latency
//  STORE      out  1  to NVRAM store pin
//  RECALLn    out  1  to NVRAM recall pin, active low
//  SIREn      out  1  to NVRAM SIREn pin
//  addr_sel   out  1  1 = nv_addr overrides the CPU BA at the NVRAM
//  nv_addr    out  8  scan address
//  upl_addr   out  8  address of the current beat
//  upl_data   out  8  data of the current beat
//  upl_valid  out  1  beat valid
//  busy       out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset:
//   - While reset_n=0: STORE=0, RECALLn=1, SIREn=1, addr_sel=0, nv_addr=0, upl_valid=0, upl_addr=0, upl_data=0, busy=1.
//   - While reset_n=0: pending flags are cleared and the FSM enters BOOT_RECALL.
//  BOOT_RECALL/RECALL:
//   - RECALLn=0 and SIREn=0 for exactly RECALL_CYC cycles, starting on the first clock after reset release.
//   - Then go to IDLE.
//  STORE:
//   - STORE=1 and SIREn=1 for STORE_CYC cycles, then go to STORE_WAIT.
//   - STORE_WAIT: STORE=0 for COPY_CYC cycles, then go to IDLE.
//  Pending flags:
//   - Three 1-deep sticky flags: st_pend, rc_pend, up_pend.
//   - st_pend is set by store_req or by a dcok_n rising edge (edge detected against a register).
//   - rc_pend is set by recall_req; up_pend is set by upl_req.
//   - Flags are set in any state, including the same cycle the flag is consumed.
//   - Repeated requests merge into one.
//  IDLE priority, one dispatch per cycle:
//   - st_pend > rc_pend > up_pend.
//   - The dispatch clears its flag and enters STORE, RECALL or UPL_ADDR on the next cycle.
//   - Simultaneous store and recall requests run store first, then recall.
//  Upload scan:
//   - Counter k runs 0..255 with addr_sel=1 for the whole scan.
//   - UPL_ADDR: nv_addr=k.
//   - UPL_DATA: capture nv_dout into upl_data; upl_addr=k; upl_valid=1.
//   - upl_valid stays 1 with stable data until a cycle with upl_ready=1.
//   - If k=255 when the beat is accepted: go to IDLE, addr_sel=0, no wrap.
//   - Otherwise k+1 and go to UPL_ADDR.
//   - Beat throughput is at most 1 per 2 cycles.
//  CPU NVRAM writes:
//   - Only valid when busy=0.
//   - The block does not stall the CPU; the CPU polls busy.
//  Reset mid-operation:
//   - Aborts any state on the next edge and returns outputs to reset values.
//   - No partial upload beat is emitted after reset.
//  Counters:
//   - Cycle timer width is clog2(COPY_CYC+1).
//   - Loaded with N-1 on entry and decremented to 0.
// TESTING
//  1. Release reset -> RECALLn=SIREn=0 cycles 1-2, busy=0 from cycle 3, STORE=0 throughout.
//  2. store_req pulse in IDLE -> STORE=1 exactly 4 cycles, busy=1 for 1+4+512 cycles, RECALLn stays 1.
//  3. store_req x3 during STORE_WAIT -> exactly one further store cycle after the first, then IDLE.
//  4. dcok_n 0->1 in the same cycle as recall_req -> full store completes, then RECALLn low 2 cycles.
//  5. Preload mem[k]=k^8'hA5, upl_req, upl_ready toggling 1/0 -> 256 beats, upl_addr 0..255, data k^A5, no repeats; addr_sel falls after beat 255.
//  6. reset_n=0 at cycle 100 of STORE_WAIT -> STORE=0, busy=1 next edge; after release, boot recall as in test 1, no store resumes.

Source files
------------

// File: rtl/nvram_sequencer.sv
// nvram_sequencer: drives STORE/RECALLn/SIREn of an X2212-style NVRAM and scans it out for upload.
//   in : clk, reset_n (sync, active low), store_req, recall_req, dcok_n, upl_req, upl_ready, nv_dout[7:0]
//   out: STORE, RECALLn, SIREn, addr_sel, nv_addr[7:0], upl_addr[7:0], upl_data[7:0], upl_valid, busy
module nvram_sequencer #(
  parameter int STORE_CYC  = 4,
  parameter int COPY_CYC   = 512,
  parameter int RECALL_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       store_req,
  input  logic       recall_req,
  input  logic       dcok_n,
  input  logic       upl_req,
  input  logic       upl_ready,
  input  logic [7:0] nv_dout,
  output logic       STORE,
  output logic       RECALLn,
  output logic       SIREn,
  output logic       addr_sel,
  output logic [7:0] nv_addr,
  output logic [7:0] upl_addr,
  output logic [7:0] upl_data,
  output logic       upl_valid,
  output logic       busy
);
  localparam int TW = $clog2(COPY_CYC + 1);
  typedef enum logic [2:0] {S_BOOT, S_RECALL, S_STORE, S_WAIT, S_IDLE, S_UADDR, S_UDATA} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [7:0] k_q, k_d, upl_addr_q, upl_addr_d, upl_data_q, upl_data_d, nv_addr_q;
  logic st_pend_q, st_pend_d, rc_pend_q, rc_pend_d, up_pend_q, up_pend_d;
  logic upl_valid_q, upl_valid_d, dcok_q, store_q, recall_n_q, addr_sel_q, busy_q;
  logic dcok_rise;
  assign dcok_rise = dcok_n & ~dcok_q;
  always_comb begin
    state_d     = state_q;
    t_d         = t_q - TW'(t_q != '0);
    k_d         = k_q;
    st_pend_d   = st_pend_q | store_req | dcok_rise;
    rc_pend_d   = rc_pend_q | recall_req;
    up_pend_d   = up_pend_q | upl_req;
    upl_valid_d = upl_valid_q;
    upl_addr_d  = upl_addr_q;
    upl_data_d  = upl_data_q;
    case (state_q)
      S_BOOT, S_RECALL, S_WAIT: if (t_q == '0) state_d = S_IDLE;
      S_STORE: if (t_q == '0) begin
        state_d = S_WAIT;
        t_d     = TW'(COPY_CYC - 1);
      end
      // A request arriving in the dispatch cycle re-arms the flag it is clearing.
      S_IDLE: if (st_pend_q) begin
        state_d   = S_STORE;
        t_d       = TW'(STORE_CYC - 1);
        st_pend_d = store_req | dcok_rise;
      end else if (rc_pend_q) begin
        state_d   = S_RECALL;
        t_d       = TW'(RECALL_CYC - 1);
        rc_pend_d = recall_req;
      end else if (up_pend_q) begin
        state_d   = S_UADDR;
        k_d       = '0;
        up_pend_d = upl_req;
      end
      S_UADDR: state_d = S_UDATA;
      // First UDATA cycle is when the registered NVRAM read of nv_addr is valid.
      S_UDATA: if (!upl_valid_q) begin
        upl_valid_d = 1'b1;
        upl_addr_d  = k_q;
        upl_data_d  = nv_dout;
      end else if (upl_ready) begin
        upl_valid_d = 1'b0;
        if (k_q == 8'hff) state_d = S_IDLE;
        else begin
          k_d     = k_q + 8'd1;
          state_d = S_UADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    dcok_q <= dcok_n;
    if (!reset_n) begin
      state_q     <= S_BOOT;
      // One extra count: the boot recall starts on the release edge, not during reset.
      t_q         <= TW'(RECALL_CYC);
      k_q         <= '0;
      st_pend_q   <= 1'b0;
      rc_pend_q   <= 1'b0;
      up_pend_q   <= 1'b0;
      upl_valid_q <= 1'b0;
      upl_addr_q  <= '0;
      upl_data_q  <= '0;
      store_q     <= 1'b0;
      recall_n_q  <= 1'b1;
      addr_sel_q  <= 1'b0;
      nv_addr_q   <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      k_q         <= k_d;
      st_pend_q   <= st_pend_d;
      rc_pend_q   <= rc_pend_d;
      up_pend_q   <= up_pend_d;
      upl_valid_q <= upl_valid_d;
      upl_addr_q  <= upl_addr_d;
      upl_data_q  <= upl_data_d;
      store_q     <= state_d == S_STORE;
      recall_n_q  <= !(state_d inside {S_BOOT, S_RECALL});
      addr_sel_q  <= state_d inside {S_UADDR, S_UDATA};
      nv_addr_q   <= k_d;
      // Pending work keeps busy high so a polling CPU never sees a gap before dispatch.
      busy_q      <= state_d != S_IDLE || st_pend_d || rc_pend_d || up_pend_d;
    end
  end
  assign STORE     = store_q;
  assign RECALLn   = recall_n_q;
  assign SIREn     = recall_n_q;
  assign addr_sel  = addr_sel_q;
  assign nv_addr   = nv_addr_q;
  assign upl_addr  = upl_addr_q;
  assign upl_data  = upl_data_q;
  assign upl_valid = upl_valid_q;
  assign busy      = busy_q;
endmodule
